// File: rtl/buffer_double_ctrl.sv
// buffer_double_ctrl: ping-pong accumulation bank controller.
// One bank accumulates incoming beats while the other holds the last
// completed window for the consumer. The banks swap at the end of every window.
// Optional build macro BUFFER_DOUBLE_CTRL_OVRUN_EN: when it is defined, a window
// that completes while the other bank is still unread overwrites that bank
// instead of stalling, and the sticky oOverrun flag records the overwrite.
//
// state | meaning
// IDLE  | waiting for a start with a non-zero window length
// CLR   | clearing the accumulating bank before the first window
// ACC   | accepting beats into bank oAccSel
// WAIT  | window done but previous result still unread; input stalled
// SWAP  | banks exchanged, result announced, new bank cleared unless stopping
module buffer_double_ctrl #(
    parameter int CWID = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iStart,
    input  logic [CWID-1:0] iLen,
    input  logic            iStop,
    input  logic            iValid,
    input  logic            iRdAck,
    output logic            oAccSel,
    output logic            oClear,
    output logic            oInReady,
    output logic            oDone,
    output logic            oDoneBank,
    output logic            oPending,
    output logic            oBusy,
    output logic [CWID-1:0] oWinCnt
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
    ,
    output logic            oOverrun
`endif
);

`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
    localparam bit OVRUN_EN = 1'b1;
`else
    localparam bit OVRUN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ACC,
        ST_WAIT,
        ST_SWAP
    } state_t;

    state_t          state_q, state_d;
    logic            acc_sel_q, acc_sel_d;
    logic            done_bank_q, done_bank_d;
    logic            pending_q, pending_d;
    logic            stop_q, stop_d;
    logic [CWID-1:0] len_q, len_d;
    logic [CWID-1:0] win_cnt_q, win_cnt_d;

    logic start_ok;
    logic beat;
    logic last_beat;
    logic to_swap;

    assign start_ok  = (state_q == ST_IDLE) && iStart && (iLen != '0);
    assign beat      = (state_q == ST_ACC) && iValid;
    assign last_beat = beat && (win_cnt_q == len_q - CWID'(1));
    // A finished window may swap unless the other bank is still unread;
    // an ack arriving in the same cycle frees that bank just in time.
    assign to_swap   = ((state_q == ST_ACC) && last_beat && (!pending_q || iRdAck || OVRUN_EN))
                    || ((state_q == ST_WAIT) && iRdAck);

    // State and datapath registers; reset discards any window in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_sel_q   <= 1'b0;
            done_bank_q <= 1'b0;
            pending_q   <= 1'b0;
            stop_q      <= 1'b0;
            len_q       <= '0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_sel_q   <= acc_sel_d;
            done_bank_q <= done_bank_d;
            pending_q   <= pending_d;
            stop_q      <= stop_d;
            len_q       <= len_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    // Next-state and register-update decode
    always_comb begin
        state_d     = state_q;
        acc_sel_d   = acc_sel_q;
        done_bank_d = done_bank_q;
        pending_d   = pending_q;
        stop_d      = stop_q;
        len_d       = len_q;
        win_cnt_d   = win_cnt_q;

        if ((state_q != ST_IDLE) && iStop) begin
            stop_d = 1'b1;
        end
        // During SWAP the pending flag describes the result just produced,
        // so an ack there cannot refer to it.
        if (iRdAck && (state_q != ST_SWAP)) begin
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d   = ST_CLR;
                    len_d     = iLen;
                    stop_d    = 1'b0;
                    win_cnt_d = '0;
                end
            end
            ST_CLR: begin
                state_d   = ST_ACC;
                win_cnt_d = '0;
            end
            ST_ACC: begin
                if (last_beat) begin
                    // Hold the count at len-1 while stalled.
                    if (!to_swap) begin
                        state_d = ST_WAIT;
                    end
                end else if (beat) begin
                    win_cnt_d = win_cnt_q + CWID'(1);
                end
            end
            ST_WAIT: begin
                state_d = ST_WAIT;
            end
            ST_SWAP: begin
                win_cnt_d = '0;
                if (stop_q) begin
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                end else begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_swap) begin
            state_d     = ST_SWAP;
            acc_sel_d   = ~acc_sel_q;
            done_bank_d = acc_sel_q;
            pending_d   = 1'b1;
            win_cnt_d   = '0;
        end
    end

`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
    logic overrun_q;

    // Sticky overwrite flag: set when an unread bank is overwritten,
    // cleared only by the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (start_ok) begin
            overrun_q <= 1'b0;
        end else if (to_swap && pending_q && !iRdAck) begin
            overrun_q <= 1'b1;
        end
    end

    assign oOverrun = overrun_q;
`endif

    assign oAccSel   = acc_sel_q;
    assign oClear    = (state_q == ST_CLR) || ((state_q == ST_SWAP) && !stop_q);
    assign oInReady  = (state_q == ST_ACC);
    assign oDone     = (state_q == ST_SWAP);
    assign oDoneBank = done_bank_q;
    assign oPending  = pending_q;
    assign oBusy     = (state_q != ST_IDLE);
    assign oWinCnt   = win_cnt_q;

endmodule

// File: tb/tb_buffer_double_ctrl.sv
// Testbench for buffer_double_ctrl: fixed vector table, directed corner
// sequences and randomized traffic against a window-level reference model.
module tb_buffer_double_ctrl;
    localparam int CWID = 8;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
    localparam bit M_OVR = 1'b1;
`else
    localparam bit M_OVR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [CWID-1:0] len = '0;
    logic            stop = 1'b0;
    logic            valid = 1'b0;
    logic            rdack = 1'b0;
    logic            acc_sel, clear, in_ready, done, done_bank, pending, busy;
    logic [CWID-1:0] win_cnt;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
    logic            overrun;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    buffer_double_ctrl #(.CWID(CWID)) dut (
        .clk       (clk),
        .rst       (rst),
        .iStart    (start),
        .iLen      (len),
        .iStop     (stop),
        .iValid    (valid),
        .iRdAck    (rdack),
        .oAccSel   (acc_sel),
        .oClear    (clear),
        .oInReady  (in_ready),
        .oDone     (done),
        .oDoneBank (done_bank),
        .oPending  (pending),
        .oBusy     (busy),
        .oWinCnt   (win_cnt)
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
        ,
        .oOverrun  (overrun)
`endif
    );

    always #5 clk = ~clk;

    // Window-level reference model: phase flags plus beat count of the window
    bit m_active, m_clr, m_swap, m_stall, m_stop, m_sel, m_dbank, m_pend;
    int m_len, m_cnt;
    bit n_active, n_clr, n_swap, n_stall, n_stop, n_sel, n_dbank, n_pend;
    int n_len, n_cnt;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
    bit m_ovr, n_ovr;
`endif

    typedef struct {
        bit start;
        int len;
        bit stop;
        bit valid;
        bit rdack;
        bit clear;
        bit ready;
        bit done;
        bit dbank;
        bit asel;
        bit pend;
        bit busy;
        int cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_clr = 0; m_swap = 0; m_stall = 0;
        m_stop = 0; m_sel = 0; m_dbank = 0; m_pend = 0;
        m_len = 0; m_cnt = 0;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
        m_ovr = 0;
`endif
    endtask

    task automatic model_next();
        bit rdy, beat, ended;
        n_active = m_active; n_clr = m_clr; n_swap = m_swap; n_stall = m_stall;
        n_stop = m_stop; n_sel = m_sel; n_dbank = m_dbank; n_pend = m_pend;
        n_len = m_len; n_cnt = m_cnt;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
        n_ovr = m_ovr;
`endif
        rdy = m_active && !m_clr && !m_swap && !m_stall;
        beat = rdy && valid;
        if (!m_active) begin
            if (rdack) n_pend = 0;
            if (start && len != 0) begin
                n_active = 1; n_clr = 1; n_len = int'(len); n_stop = 0; n_cnt = 0;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
                n_ovr = 0;
`endif
            end
        end else begin
            if (stop) n_stop = 1;
            if (m_swap) begin
                n_swap = 0; n_cnt = 0;
                if (m_stop) begin
                    n_active = 0; n_stop = 0;
                end
            end else begin
                if (rdack) n_pend = 0;
                if (m_clr) begin
                    n_clr = 0; n_cnt = 0;
                end else begin
                    ended = m_stall || (beat && (m_cnt + 1 == m_len));
                    if (ended && (!m_pend || rdack || M_OVR)) begin
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
                        if (m_pend && !rdack) n_ovr = 1;
`endif
                        n_swap = 1; n_stall = 0; n_sel = !m_sel; n_dbank = m_sel;
                        n_pend = 1; n_cnt = 0;
                    end else if (ended) begin
                        n_stall = 1;
                    end else if (beat) begin
                        n_cnt = m_cnt + 1;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        m_active = n_active; m_clr = n_clr; m_swap = n_swap; m_stall = n_stall;
        m_stop = n_stop; m_sel = n_sel; m_dbank = n_dbank; m_pend = n_pend;
        m_len = n_len; m_cnt = n_cnt;
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
        m_ovr = n_ovr;
`endif
    endtask

    task automatic check_model();
        chk("clear", clear, m_clr || (m_swap && !m_stop));
        chk("in_ready", in_ready, m_active && !m_clr && !m_swap && !m_stall);
        chk("done", done, m_swap);
        chk("done_bank", done_bank, m_dbank);
        chk("acc_sel", acc_sel, m_sel);
        chk("pending", pending, m_pend);
        chk("busy", busy, m_active);
        chk("win_cnt", win_cnt, m_cnt);
`ifdef BUFFER_DOUBLE_CTRL_OVRUN_EN
        chk("overrun", overrun, m_ovr);
`endif
    endtask

    // Inputs are set before the call; they are sampled at the next rising edge
    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        model_commit();
        cyc++;
        check_model();
    endtask

    // Assert reset between edges so the async response is visible before any clock
    task automatic apply_reset();
        start = 0; stop = 0; valid = 0; rdack = 0; len = '0;
        rst = 1;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic wait_done(input int max, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    initial begin
        //        st len sp va ra | clr rdy dn db as pd by cnt
        tbl[0] = '{1, 4, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{0, 4, 0, 1, 0,  0, 1, 0, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 4, 0, 1, 0,  0, 1, 0, 0, 0, 0, 1, 1};
        tbl[3] = '{0, 4, 0, 1, 0,  0, 1, 0, 0, 0, 0, 1, 2};
        tbl[4] = '{0, 4, 0, 1, 0,  0, 1, 0, 0, 0, 0, 1, 3};
        tbl[5] = '{0, 4, 0, 1, 0,  1, 0, 1, 0, 1, 1, 1, 0};
        tbl[6] = '{0, 4, 0, 1, 0,  0, 1, 0, 0, 1, 1, 1, 0};

        // First window with constant valid, compared against the table
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            start = tbl[i].start; len = CWID'(tbl[i].len); stop = tbl[i].stop;
            valid = tbl[i].valid; rdack = tbl[i].rdack;
            tick();
            chk("t_clear", clear, tbl[i].clear);
            chk("t_ready", in_ready, tbl[i].ready);
            chk("t_done", done, tbl[i].done);
            chk("t_dbank", done_bank, tbl[i].dbank);
            chk("t_asel", acc_sel, tbl[i].asel);
            chk("t_pend", pending, tbl[i].pend);
            chk("t_busy", busy, tbl[i].busy);
            chk("t_cnt", win_cnt, tbl[i].cnt);
        end

        // Zero-length start ignored; gappy valid; iLen change after latch
        apply_reset();
        start = 1; len = 0; tick();
        chk("len0_ignored", busy, 0);
        start = 1; len = 4; valid = 1; tick();
        chk("clr_pulse", clear, 1);
        start = 0; len = 7; valid = 0; tick();
        for (int k = 0; k < 7; k++) begin
            valid = (k % 2 == 0);
            tick();
            if (k < 6) chk("win_cnt_tog", win_cnt, k / 2 + 1);
            else chk("done_tog", done, 1);
        end
        chk("done_bank_tog", done_bank, 0);

`ifndef BUFFER_DOUBLE_CTRL_OVRUN_EN
        // Unread first result: second completion stalls until ack
        valid = 1; tick();
        for (int k = 0; k < 4; k++) tick();
        chk("wait_ready", in_ready, 0);
        chk("wait_busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("wait_hold", in_ready, 0);
        end
        rdack = 1; tick();
        chk("ack_swap_done", done, 1);
        chk("ack_swap_bank", done_bank, 1);
        rdack = 0; valid = 0; tick();
`else
        // Unread first result is overwritten without a stall
        valid = 1; tick();
        for (int k = 0; k < 4; k++) tick();
        chk("ovr_done", done, 1);
        chk("ovr_flag", overrun, 1);
        chk("ovr_bank", done_bank, 1);
        valid = 0; tick(); tick();
        chk("ovr_sticky", overrun, 1);
        stop = 1; valid = 1; tick();
        stop = 0;
        for (int k = 0; k < 12 && busy; k++) tick();
        chk("ovr_idle", busy, 0);
        chk("ovr_idle_sticky", overrun, 1);
        start = 1; len = 2; tick();
        start = 0;
        chk("ovr_cleared", overrun, 0);
`endif

        // Stop requested during the second window of length 3
        apply_reset();
        start = 1; len = 3; valid = 1; tick();
        start = 0; tick();
        for (int k = 0; k < 3; k++) tick();
        chk("first_done", done, 1);
        tick();
        stop = 1; rdack = 1; tick();
        chk("ack_clears", pending, 0);
        stop = 0; rdack = 0;
        wait_done(10, "stop_win_done");
        chk("stop_no_clear", clear, 0);
        tick();
        chk("stop_idle", busy, 0);
        chk("stop_pending", pending, 1);
        tick();
        chk("stop_not_ready", in_ready, 0);

        // Reset mid-window, then a fresh short run
        apply_reset();
        start = 1; len = 5; valid = 1; tick();
        start = 0; tick(); tick(); tick();
        chk("mid_cnt", win_cnt, 2);
        apply_reset();
        chk("rst_busy", busy, 0);
        chk("rst_asel", acc_sel, 0);
        chk("rst_cnt", win_cnt, 0);
        start = 1; len = 2; valid = 1; tick();
        chk("re_clear", clear, 1);
        chk("re_asel", acc_sel, 0);
        start = 0; tick(); tick(); tick();
        chk("re_done", done, 1);
        chk("re_dbank", done_bank, 0);
        chk("re_asel1", acc_sel, 1);

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                start = ($urandom_range(0, 7) == 0);
                len   = CWID'($urandom_range(0, 5));
                stop  = ($urandom_range(0, 15) == 0);
                valid = ($urandom_range(0, 3) != 0);
                rdack = ($urandom_range(0, 5) == 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_double_ctrl.md
BUFFER_DOUBLE_CTRL -- requirements
Module: buffer_double_ctrl

Interface
REQ-001 Parameter CWID, 8: width of window-length input and beat counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 iStart  in  1  start pulse; sampled in IDLE only.
REQ-005 iLen  in  CWID  accumulation window length in accepted beats; latched on accepted iStart.
REQ-006 iStop  in  1  request to end after the current window; sticky until that window ends.
REQ-007 iValid  in  1  upstream bitstream beat valid.
REQ-008 iRdAck  in  1  consumer has read the completed (non-accumulating) bank.
REQ-009 oAccSel  out  1  bank currently accumulating; drives the double-buffer array accumulate-select.
REQ-010 oClear  out  1  one-cycle pulse; clears bank oAccSel in the array.
REQ-011 oInReady  out  1  beat accepted this cycle when iValid&oInReady; upstream drives zeros otherwise.
REQ-012 oDone  out  1  one-cycle pulse: a window completed.
REQ-013 oDoneBank  out  1  bank holding the completed result; valid with oDone, held until next oDone.
REQ-014 oPending  out  1  a completed bank is unread.
REQ-015 oBusy  out  1  state != IDLE.
REQ-016 oWinCnt  out  CWID  beats accepted in current window.

Function
REQ-017 States: IDLE, CLR, ACC, WAIT, SWAP.
REQ-018 IDLE: iStart with iLen!=0 -> latch iLen, clear stop flag, go CLR; iStart with iLen==0 ignored; iStart outside IDLE ignored.
REQ-019 CLR: oClear=1, oInReady=0, oWinCnt=0, one cycle, then ACC.
REQ-020 ACC: oInReady=1; each accepted beat increments oWinCnt; beat accepted at oWinCnt==len-1 completes the window.
REQ-021 Completion with oPending=0, or iRdAck in the same cycle: go SWAP next cycle.
REQ-022 Completion with oPending=1 and no iRdAck: go WAIT; oInReady=0; stay until iRdAck, then SWAP.
REQ-023 SWAP, one cycle: oAccSel toggles; oDone=1; oDoneBank=old oAccSel; oPending=1; oWinCnt=0; oInReady=0.
REQ-024 SWAP with the stop flag clear: oClear=1 in the same cycle (clears new bank), then ACC. Stop flag set: oClear=0, clear stop flag, then IDLE.
REQ-025 Accumulate-to-accumulate gap: exactly one non-ready cycle (SWAP) when not stalled.
REQ-026 iRdAck clears oPending next cycle. iRdAck with oPending=0 is ignored. iRdAck in SWAP is ignored because the new result is pending.
REQ-027 iStop in any non-IDLE state sets the stop flag. iStop in IDLE is ignored.
REQ-028 oWinCnt never exceeds len-1; the counter wraps to 0 only via SWAP/CLR.
REQ-029 iLen changes after latch have no effect until the next accepted iStart.

Reset
REQ-030 rst asserted at any time -> IDLE, oAccSel=0, oClear=0, oInReady=0, oDone=0, oDoneBank=0, oPending=0, oBusy=0, oWinCnt=0, stop flag=0, latched len=0.
REQ-031 Reset mid-window discards the window. The next start's CLR clears the accumulating bank. The other bank's contents are undefined until a window completes into it.

Configuration
REQ-032 Macro BUFFER_DOUBLE_CTRL_OVRUN_EN.
- Defined: completion with oPending=1 skips WAIT and goes straight to SWAP, overwriting the unread bank. Sticky output oOverrun (1 bit, reset 0) sets and clears only on an accepted iStart.
- Undefined: the REQ-022 stall applies, and no oOverrun port exists.

Verification
REQ-033 Reset release, iStart with iLen=4, iValid=1 constant -> oClear at cycle 1; oInReady cycles 2-5; SWAP cycle 6: oDone=1, oDoneBank=0, oAccSel->1, oClear=1.
REQ-034 iLen=4 with iValid toggling 1,0,1,0 -> oWinCnt advances only on valid beats; oDone 1 cycle after the 4th accepted beat.
REQ-035 Continuous mode, no iRdAck after the first oDone -> second completion enters WAIT with oInReady=0. iRdAck 5 cycles later -> SWAP next cycle, oDoneBank=1.
REQ-036 iStop during second window of iLen=3 -> SWAP with oClear=0, then IDLE, oBusy=0, oPending=1; further iValid gets oInReady=0.
REQ-037 rst pulsed mid-ACC at oWinCnt=2 -> all outputs at reset values asynchronously. New iStart with iLen=2 -> normal CLR/ACC sequence, oAccSel=0.
REQ-038 With BUFFER_DOUBLE_CTRL_OVRUN_EN, second completion without iRdAck -> no WAIT, oDone pulses, oOverrun=1 until next iStart.
